// File: rtl/s_spi_sampler.sv
// Oversampled SPI mode-0 slave byte engine clocked entirely by clk (MSB first).
// Optional macro S_SPI_GLITCH_FILTER_EN: accept SCLK/SS levels only after 2 stable clk cycles.
module s_spi_sampler #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic              frame_start,
  output logic              frame_end,
  output logic              frame_abort,
  output logic [5:0]        byte_cnt,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [2:0]        PIN_RST  = 3'b100;  // {SS, MOSI, SCLK}

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [2:0]             pins;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_stable, ss_stable;
  logic                   sclk_lvl_q, ss_lvl_q, ss_armed_q;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  state_t                 state_q;
  logic [DATA_W-1:0]      tx_shift_q, rx_data_q;
  logic [DATA_W-2:0]      rx_shift_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [5:0]             byte_cnt_q;
  logic                   word_seen_q, miso_q;
  logic                   rx_valid_q, tx_load_q, frame_start_q, frame_end_q, frame_abort_q;

  assign pins = {SS, MOSI, SCLK};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q[gi] <= {SYNC_STAGES{PIN_RST[gi]}};
        end else begin
          sync_q[gi] <= {sync_q[gi][SYNC_STAGES-2:0], pins[gi]};
        end
      end
    end
  endgenerate

  assign sclk_s = sync_q[0][SYNC_STAGES-1];
  assign mosi_s = sync_q[1][SYNC_STAGES-1];
  assign ss_s   = sync_q[2][SYNC_STAGES-1];

`ifdef S_SPI_GLITCH_FILTER_EN
  logic sclk_d1_q, ss_d1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d1_q <= 1'b0;
      ss_d1_q   <= 1'b1;
    end else begin
      sclk_d1_q <= sclk_s;
      ss_d1_q   <= ss_s;
    end
  end

  assign sclk_stable = (sclk_s == sclk_d1_q);
  assign ss_stable   = (ss_s == ss_d1_q);
`else
  assign sclk_stable = 1'b1;
  assign ss_stable   = 1'b1;
`endif

  // primed_q marks when ss_s carries a real post-reset pin sample; a frame may
  // only start after SS has been seen high from then on.
  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q   <= '0;
      sclk_lvl_q <= 1'b0;
      ss_lvl_q   <= 1'b1;
      ss_armed_q <= 1'b0;
    end else begin
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      if (sclk_stable) sclk_lvl_q <= sclk_s;
      if (ss_stable)   ss_lvl_q   <= ss_s;
      if (primed_q[SYNC_STAGES-1] && ss_stable && ss_s) ss_armed_q <= 1'b1;
    end
  end

  assign sclk_rise = sclk_stable &  sclk_s & ~sclk_lvl_q;
  assign sclk_fall = sclk_stable & ~sclk_s &  sclk_lvl_q;
  assign ss_rise   = ss_stable   &  ss_s   & ~ss_lvl_q;
  assign ss_fall   = ss_stable   & ~ss_s   &  ss_lvl_q & ss_armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      word_seen_q   <= 1'b0;
      miso_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_load_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_load_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_abort_q <= 1'b0;
      miso_q        <= (state_q == ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q       <= ACTIVE;
            tx_shift_q    <= tx_data;
            tx_load_q     <= 1'b1;
            frame_start_q <= 1'b1;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            rx_shift_q    <= '0;
            word_seen_q   <= 1'b0;
          end
        end
        ACTIVE: begin
          // SS edges win; a coincident SCLK edge is dropped.
          if (ss_rise) begin
            state_q       <= IDLE;
            frame_end_q   <= 1'b1;
            frame_abort_q <= (bit_cnt_q != '0);
            bit_cnt_q     <= '0;
          end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[DATA_W-3:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_q   <= {rx_shift_q, mosi_s};
              rx_valid_q  <= 1'b1;
              byte_cnt_q  <= byte_cnt_q + 6'd1;
              bit_cnt_q   <= '0;
              word_seen_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt_q == '0 && word_seen_q) begin
              tx_shift_q <= tx_data;
              tx_load_q  <= 1'b1;
            end else begin
              tx_shift_q <= tx_shift_q << 1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_load     = tx_load_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_abort = frame_abort_q;
  assign byte_cnt    = byte_cnt_q;
  assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_s_spi_sampler.sv
// Self-checking bench for s_spi_sampler: table-driven frames plus corner-case sequences,
// received words checked through a scoreboard queue.
module tb_s_spi_sampler;

  localparam int HALF = 8;  // SCLK = clk/16
`ifdef S_SPI_GLITCH_FILTER_EN
  localparam int         FILT      = 1;
  localparam logic [7:0] GLITCH_RX = 8'h12;
  localparam int         GLITCH_AB = 0;
`else
  localparam int         FILT      = 0;
  localparam logic [7:0] GLITCH_RX = 8'h11;
  localparam int         GLITCH_AB = 1;
`endif
  localparam int EXP_LAT = 2 + 1 + FILT;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [5:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, SCLK, MOSI, SS;
  logic [7:0] tx_data;
  logic       MISO, rx_valid, tx_load, frame_start, frame_end, frame_abort, busy;
  logic [7:0] rx_data;
  logic [5:0] byte_cnt;

  s_spi_sampler dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
    .frame_start(frame_start), .frame_end(frame_end), .frame_abort(frame_abort),
    .byte_cnt(byte_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_bad = 0;
  int         cyc = 0;
  int         n_rxv = 0, n_txl = 0, n_fs = 0, n_fe = 0, n_fa = 0, n_coin = 0;
  int         s_rxv, s_txl, s_fs, s_fe, s_fa, s_coin;
  int         rise_cyc = 0, rx_cyc = 0;
  logic [7:0] miso_cap;
  logic [5:0] exp_cnt;
  exp_t       sb_q[$];
  exp_t       mon_e;
  vec_t       vecs[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        n_rxv++;
        rx_cyc = cyc;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_unexpected: got rx_data 0x%0h, required no rx_valid", rx_data);
        end else begin
          mon_e = sb_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
          check("rx_byte_cnt", {26'd0, byte_cnt}, {26'd0, mon_e.cnt});
        end
        if (tx_load) check("rxv_txl_only_at_start", {31'd0, frame_start}, 32'd1);
      end
      if (tx_load)     n_txl++;
      if (frame_start) n_fs++;
      if (frame_end)   n_fe++;
      if (frame_abort) begin
        n_fa++;
        check("abort_with_end", {31'd0, frame_end}, 32'd1);
      end
      if (frame_end && frame_abort) n_coin++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_rxv = n_rxv; s_txl = n_txl; s_fs = n_fs; s_fe = n_fe; s_fa = n_fa; s_coin = n_coin;
  endtask

  task automatic expect_rx(input logic [7:0] d);
    exp_t e;
    exp_cnt = exp_cnt + 6'd1;
    e.data  = d;
    e.cnt   = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic spi_bit(input logic b, input logic do_fall, input logic glitch);
    MOSI = b;
    if (glitch) begin
      wait_clk(4);
      SCLK = 1'b1;
      wait_clk(1);
      SCLK = 1'b0;
      wait_clk(HALF - 5);
    end else begin
      wait_clk(HALF);
    end
    miso_cap = {miso_cap[6:0], MISO};
    SCLK     = 1'b1;
    rise_cyc = cyc;
    wait_clk(HALF);
    if (do_fall) SCLK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int glitch_bit);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], !(last && i == 0), i == glitch_bit);
  endtask

  task automatic begin_frame();
    exp_cnt = '0;
    SS = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic end_frame();
    SS = 1'b1;
    wait_clk(HALF);
    SCLK = 1'b0;
    wait_clk(HALF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'h5A, 8'h81, 8'h5A, 8'h81};

    rst = 1'b1; SCLK = 1'b0; MOSI = 1'b0; SS = 1'b1; tx_data = 8'h00;
    miso_cap = '0; exp_cnt = '0;
    wait_clk(4);
    check("reset_outputs", {13'd0, MISO, rx_data, rx_valid, tx_load, frame_start,
                            frame_end, frame_abort, byte_cnt, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(HALF);

    for (int i = 0; i < 4; i++) begin
      tx_data = vecs[i].tx;
      snap();
      begin_frame();
      check("busy_active", {31'd0, busy}, 32'd1);
      expect_rx(vecs[i].exp_rx);
      send_byte(vecs[i].mosi, 1'b1, -1);
      end_frame();
      check("miso_byte", {24'd0, miso_cap}, {24'd0, vecs[i].exp_miso});
      check("frame_start_cnt", n_fs - s_fs, 32'd1);
      check("tx_load_cnt", n_txl - s_txl, 32'd1);
      check("rx_valid_cnt", n_rxv - s_rxv, 32'd1);
      check("frame_end_cnt", n_fe - s_fe, 32'd1);
      check("frame_abort_cnt", n_fa - s_fa, 32'd0);
      check("byte_cnt_hold", {26'd0, byte_cnt}, 32'd1);
      check("rx_latency", rx_cyc - rise_cyc, EXP_LAT);
      check("busy_idle", {31'd0, busy}, 32'd0);
    end

    // 65-word frame: byte_cnt wraps, tx_load at start and after words 1..64.
    tx_data = 8'h96;
    snap();
    begin_frame();
    for (int k = 0; k < 65; k++) begin
      expect_rx(8'(k));
      send_byte(8'(k), k == 64, -1);
    end
    end_frame();
    check("long_rx_valid_cnt", n_rxv - s_rxv, 32'd65);
    check("long_tx_load_cnt", n_txl - s_txl, 32'd65);
    check("long_byte_cnt_wrap", {26'd0, byte_cnt}, 32'd1);

    // Partial word then SS high.
    snap();
    begin_frame();
    for (int k = 0; k < 5; k++) spi_bit(1'b1, 1'b1, 1'b0);
    end_frame();
    check("abort_rx_valid_cnt", n_rxv - s_rxv, 32'd0);
    check("abort_frame_end_cnt", n_fe - s_fe, 32'd1);
    check("abort_cnt", n_fa - s_fa, 32'd1);
    check("abort_coincident", n_coin - s_coin, 32'd1);
    snap();
    begin_frame();
    expect_rx(8'h12);
    send_byte(8'h12, 1'b1, -1);
    end_frame();
    check("after_abort_rx_cnt", n_rxv - s_rxv, 32'd1);
    check("after_abort_no_abort", n_fa - s_fa, 32'd0);

    // Reset mid-frame with SS held low.
    snap();
    begin_frame();
    for (int k = 0; k < 4; k++) spi_bit(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    wait_clk(2);
    check("midreset_outputs", {13'd0, MISO, rx_data, rx_valid, tx_load, frame_start,
                               frame_end, frame_abort, byte_cnt, busy}, 32'd0);
    rst = 1'b0;
    send_byte(8'hC3, 1'b0, -1);
    wait_clk(HALF);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_rx_cnt", n_rxv - s_rxv, 32'd0);
    end_frame();
    check("midreset_no_frame_end", n_fe - s_fe, 32'd0);
    snap();
    begin_frame();
    expect_rx(8'h3C);
    send_byte(8'h3C, 1'b1, -1);
    end_frame();
    check("post_reset_rx_cnt", n_rxv - s_rxv, 32'd1);

    // One-cycle SCLK glitch in the low phase before bit 3.
    snap();
    begin_frame();
    expect_rx(GLITCH_RX);
    send_byte(8'h12, 1'b1, 3);
    end_frame();
    check("glitch_rx_cnt", n_rxv - s_rxv, 32'd1);
    check("glitch_abort_cnt", n_fa - s_fa, GLITCH_AB);

    // SCLK activity while deselected.
    snap();
    for (int k = 0; k < 10; k++) begin
      SCLK = 1'b1;
      wait_clk(4);
      check("idle_miso", {31'd0, MISO}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      SCLK = 1'b0;
      wait_clk(4);
    end
    wait_clk(HALF);
    check("idle_strobes", (n_rxv - s_rxv) + (n_txl - s_txl) + (n_fs - s_fs) +
                          (n_fe - s_fe) + (n_fa - s_fa), 32'd0);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/s_spi_sampler.md
Name: s_spi_sampler

Overview:
- Oversampled SPI slave byte engine running entirely in the system `clk` domain.
- Synchronises raw SCLK/MOSI/SS pins, deserialises MOSI bytes and serialises MISO bytes (SPI mode 0, MSB first).
- Hands bytes to and from the top-level message logic with single-cycle strobes.
- Sits directly between the board SPI pins and the slave message/display buffers; gives a glitch-safe clk-domain alternative to the SCLK-clocked byte interface.

Parameters:
- DATA_W, 8, bits per SPI word.
- SYNC_STAGES, 2, flip-flop depth of the pin synchronisers (legal values 2..4).

Ports:
- clk  input  1  system clock (27 MHz on board).
- rst  input  1  synchronous, active-high reset.
- SCLK  input  1  raw SPI clock pin from master.
- MOSI  input  1  raw SPI data-in pin.
- SS  input  1  raw SPI slave select, active low.
- MISO  output  1  SPI data-out pin.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle strobe: rx_data updated this cycle.
- tx_data  input  DATA_W  next word to transmit; must be stable whenever tx_load can fire.
- tx_load  output  1  one-cycle strobe: tx_data captured into the shifter this cycle.
- frame_start  output  1  one-cycle strobe on synchronised SS falling edge.
- frame_end  output  1  one-cycle strobe on synchronised SS rising edge.
- frame_abort  output  1  one-cycle strobe, coincident with frame_end, when the frame ended with a partial word (bit_cnt != 0).
- byte_cnt  output  6  complete words received in the current frame, wrapping 63 -> 0.
- busy  output  1  high while in ACTIVE state.

Behaviour:
- Synchronisers: SCLK, MOSI, SS each pass through SYNC_STAGES flops. All logic uses the synchronised copies, referred to as sclk_s, mosi_s, ss_s. An additional flop on sclk_s and ss_s provides edge detection.
- Clock ratio: clk must be at least 8x SCLK. With clk = 27 MHz, SCLK is at most 3.375 MHz.
- Reset values:
  - MISO = 0, rx_data = 0, byte_cnt = 0.
  - All strobes = 0, busy = 0, state = IDLE.
  - Shift registers and bit_cnt are cleared.
  - Synchroniser flops reset to SCLK = 0, SS = 1, MOSI = 0, so deassertion of rst causes no false edge.
- FSM: IDLE, ACTIVE.
  - IDLE -> ACTIVE on ss_s falling edge. In that cycle:
    - tx_shift <= tx_data, tx_load = 1, frame_start = 1.
    - bit_cnt <= 0, byte_cnt <= 0, rx_shift <= 0.
  - ACTIVE, sclk_s rising edge:
    - rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}, bit_cnt++.
    - If bit_cnt was DATA_W-1: rx_data <= {rx_shift[DATA_W-2:0], mosi_s}, rx_valid = 1, byte_cnt++ (wraps), bit_cnt <= 0.
  - ACTIVE, sclk_s falling edge:
    - If bit_cnt == 0 and at least one word has completed in this frame: tx_shift <= tx_data, tx_load = 1.
    - Otherwise tx_shift <= tx_shift << 1.
  - ACTIVE -> IDLE on ss_s rising edge. In that cycle:
    - frame_end = 1.
    - frame_abort = 1 if bit_cnt != 0; the partial word is discarded and rx_valid is not raised.
    - bit_cnt <= 0. byte_cnt holds until the next frame_start.
- SS edges take priority over a coincident SCLK edge in the same cycle; that SCLK edge is ignored.
- SCLK edges while in IDLE are ignored.
- MISO = tx_shift[DATA_W-1] while in ACTIVE, 0 in IDLE. It is a registered output.
- Latency (pin edge to strobe):
  - rx_valid follows the 8th SCLK rising pin edge by SYNC_STAGES+1 clk cycles.
  - MISO updates SYNC_STAGES+2 clk cycles after an SCLK falling pin edge; this must be shorter than half an SCLK period.
- rx_valid and tx_load can assert in the same cycle only through the frame_start path, never otherwise.
- rst asserted mid-frame: everything returns to reset values immediately; no frame_end is issued. After rst deasserts with SS still low, the block waits for a fresh SS falling edge.

Optional Feature:
- Macro: S_SPI_GLITCH_FILTER_EN.
- When defined:
  - An sclk_s or ss_s transition is accepted only after the new level has been stable for 2 consecutive clk cycles.
  - Pulses of 1 clk cycle are rejected.
  - All latencies above increase by 1 cycle; minimum clk/SCLK ratio becomes 10.
- When undefined: edges are taken directly from the synchroniser output, as described above.

Test Plan:
- Reset, then SS low, send 0xA5 at SCLK = clk/16 with tx_data = 0x3C, then SS high:
  - frame_start and tx_load pulse once.
  - MISO bits 0,0,1,1,1,1,0,0.
  - One rx_valid with rx_data = 0xA5, 3 clk after the 8th rising edge.
  - byte_cnt = 1, frame_end = 1, frame_abort = 0.
- One frame of 65 words 0x00..0x40:
  - 65 rx_valid strobes with matching rx_data.
  - byte_cnt wraps to 1.
  - tx_load fires 65 times (once at start, plus after words 1..64).
- SS high after 5 bits of 0xFF:
  - No rx_valid.
  - frame_end and frame_abort in the same cycle.
  - The next frame sending 0x12 receives exactly 0x12.
- rst pulse after 4 bits with SS held low, then continue clocking:
  - All outputs are 0 and busy = 0.
  - No rx_valid until SS rises and falls again.
- With S_SPI_GLITCH_FILTER_EN defined, inject a 1-cycle SCLK high glitch mid-word:
  - The received word is unchanged.
  - Without the macro, the same stimulus corrupts the word (bit shift observed).
- SCLK toggling 10 times with SS high:
  - No strobes, MISO = 0, busy = 0.
